uart_rx: RTL

UART serial receiver: the receive-side counterpart to the transmit PISO path. It synchronises the asynchronous rx line, detects the start bit, samples each data bit at mid-bit, and assembles bits LSB-first in a serial-in/parallel-out register. It then presents the byte with a one-cycle valid strobe, or a one-cycle framing-error strobe. It sits between the board rx pin and the byte consumer (FIFO/controller).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sipo.sv | 40 ++++
 rtl/uart_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing
// constants used by both the transmitter and the receiver.
package uart_pkg;

  // 100 MHz system clock at 115200 baud.
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sipo.sv
// Serial-in/parallel-out register for the UART receiver. Serial data enters
// the MSB and shifts right, so after DATA_BITS shifts the first received bit
// sits in bit 0 (mirror of the transmit PISO, which shifts out of bit 0).
module rx_sipo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_en,
  input  logic                 din,
  output logic [DATA_BITS-1:0] q
);

  logic [DATA_BITS-1:0] shift_q, shift_d;

  // Next shift-register value: shift right on enable, otherwise hold.
  always_comb begin
    // NOTE: default assignment first so every path drives shift_d (no latch).
    shift_d = shift_q;
    if (shift_en) begin
      shift_d = {din, shift_q[DATA_BITS-1:1]};
    end
  end

  // Shift-register state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this is a datapath register, but it is cleared so a frame aborted
    // by reset can never leak stale bits into a later data_out load.
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q = shift_q;

endmodule : rx_sipo

// File: rtl/uart_rx.sv
// UART receiver: two-flop rx synchroniser, start-bit detection with a
// half-bit qualification, mid-bit sampling of DATA_BITS data bits (LSB first)
// and one stop bit. A good frame yields a one-cycle data_valid with data_out
// updated in the same cycle; a low stop bit yields a one-cycle frame_err and
// the receiver then waits for the line to return high before rearming.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  if ((CLKS_PER_BIT % 2) != 0 || CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
  end

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 sync1_q, rx_s_q;
  logic                 shift_en;
  logic [DATA_BITS-1:0] shift_word;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so both flops sample the pre-edge values.
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  rx_sipo #(
    .DATA_BITS(DATA_BITS)
  ) u_sipo (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_en(shift_en),
    .din     (rx_s_q),
    .q       (shift_word)
  );

  // Next-state, counter and strobe logic; strobes default low every cycle.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    shift_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid stop bit keeps half a bit of margin for the next start.
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_word;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        // A held-low line must not be re-read as a fresh start bit.
        clk_cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule : uart_rx
